// File: rtl/hqc_rs_pkg.sv
// Shared RS decoder definitions: parameter selection, GF(2^8) constants and
// the constant-multiplier function used by the syndrome lanes.
package hqc_rs_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;

  // alpha^i for i = 1..58, alpha = 0x02 under GF_POLY
  localparam logic [7:0] ALPHA_POW [1:58] = '{
    8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A, 8'h74,
    8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26, 8'h4C, 8'h98, 8'h2D, 8'h5A, 8'hB4,
    8'h75, 8'hEA, 8'hC9, 8'h8F, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60,
    8'hC0, 8'h9D, 8'h27, 8'h4E, 8'h9C, 8'h25, 8'h4A, 8'h94, 8'h35, 8'h6A,
    8'hD4, 8'hB5, 8'h77, 8'hEE, 8'hC1, 8'h9F, 8'h23, 8'h46, 8'h8C, 8'h05,
    8'h0A, 8'h14, 8'h28, 8'h50, 8'hA0, 8'h5D, 8'hBA, 8'h69
  };

  typedef enum logic [2:0] {
    ST_IDLE, ST_READ, ST_DRAIN, ST_OUT, ST_DONE
  } synd_state_e;

  function automatic int n1_sel(input int sec);
    case (sec)
      192:     return 56;
      256:     return 90;
      default: return 46;
    endcase
  endfunction

  function automatic int delta_sel(input int sec);
    case (sec)
      192:     return 16;
      256:     return 29;
      default: return 15;
    endcase
  endfunction

  function automatic int aw_sel(input int sec);
    return (sec == 256) ? 7 : 6;
  endfunction

  // With c a constant this folds down to a fixed XOR network on x.
  function automatic logic [7:0] gf256_mul_const(input logic [7:0] x, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = x;
    for (int b = 0; b < 8; b++) begin
      if (c[b]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/hqc_rsdecod_synd_cell.sv
// One syndrome lane: Horner accumulator S <= S*alpha^IDX ^ din.
// HQC_RS_SYND_ZERO_DETECT_EN adds the nz port (next value non-zero).
module hqc_rsdecod_synd_cell
  import hqc_rs_pkg::*;
#(
  parameter int IDX = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
`ifdef HQC_RS_SYND_ZERO_DETECT_EN
  output logic       nz,
`endif
  output logic [7:0] acc
);

  localparam logic [7:0] ALPHA_I = ALPHA_POW[IDX];

  logic [7:0] acc_nxt;

  always_comb begin
    acc_nxt = acc;
    if (clr)     acc_nxt = '0;
    else if (en) acc_nxt = gf256_mul_const(acc, ALPHA_I) ^ din;
  end

`ifdef HQC_RS_SYND_ZERO_DETECT_EN
  assign nz = |acc_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= acc_nxt;
  end

endmodule

// File: rtl/hqc_rsdecod_syndrome.sv
// RS syndrome stage: Horner-reads N1 bytes from RAM, streams 2*DELTA syndromes.
// HQC_RS_SYND_ZERO_DETECT_EN enables the all-zero syndrome flag.
module hqc_rsdecod_syndrome
  import hqc_rs_pkg::*;
#(
  parameter int PARAM_SECURITY = 128,
  parameter int N1             = n1_sel(PARAM_SECURITY),
  parameter int DELTA          = delta_sel(PARAM_SECURITY),
  parameter int AW             = aw_sel(PARAM_SECURITY),
  parameter int IW             = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic [7:0]    ram_din_i,
  output logic          ram_din_rd_o,
  output logic [AW-1:0] ram_din_addr_o,
  output logic [7:0]    synd_o,
  output logic [IW-1:0] synd_idx_o,
  output logic          synd_valid_o,
  input  logic          synd_ready_i,
  output logic          synd_zero_o
);

  localparam int            NS        = 2 * DELTA;
  localparam logic [AW-1:0] ADDR_LAST = AW'(N1 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NS - 1);

  synd_state_e          state;
  logic                 rd_q;   // RAM data for last cycle's read is on ram_din_i
  logic                 clr;
  logic [NS-1:0][7:0]   acc;

  assign clr = (state == ST_IDLE) && start_i;

`ifdef HQC_RS_SYND_ZERO_DETECT_EN
  logic [NS-1:0] nz;
`endif

  for (genvar g = 0; g < NS; g++) begin : g_lane
    hqc_rsdecod_synd_cell #(.IDX(g + 1)) u_cell (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .clr   (clr),
      .en    (rd_q),
      .din   (ram_din_i),
`ifdef HQC_RS_SYND_ZERO_DETECT_EN
      .nz    (nz[g]),
`endif
      .acc   (acc[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ST_IDLE;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      ram_din_rd_o   <= 1'b0;
      ram_din_addr_o <= '0;
      rd_q           <= 1'b0;
      synd_valid_o   <= 1'b0;
      synd_idx_o     <= '0;
    end else begin
      rd_q   <= ram_din_rd_o;
      done_o <= 1'b0;
      case (state)
        ST_IDLE: if (start_i) begin
          state          <= ST_READ;
          busy_o         <= 1'b1;
          ram_din_rd_o   <= 1'b1;
          ram_din_addr_o <= ADDR_LAST;
        end
        ST_READ: begin
          if (ram_din_addr_o == '0) begin
            state        <= ST_DRAIN;
            ram_din_rd_o <= 1'b0;
          end else begin
            ram_din_addr_o <= ram_din_addr_o - AW'(1);
          end
        end
        ST_DRAIN: begin
          state        <= ST_OUT;
          synd_valid_o <= 1'b1;
        end
        ST_OUT: if (synd_ready_i) begin
          if (synd_idx_o == IDX_LAST) begin
            state        <= ST_DONE;
            synd_valid_o <= 1'b0;
            synd_idx_o   <= '0;
            done_o       <= 1'b1;
          end else begin
            synd_idx_o <= synd_idx_o + IW'(1);
          end
        end
        ST_DONE: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    synd_o = 8'h00;
    for (int g = 0; g < NS; g++)
      if (synd_valid_o && synd_idx_o == IW'(g)) synd_o = acc[g];
  end

`ifdef HQC_RS_SYND_ZERO_DETECT_EN
  logic zero_q;
  // sampled on the DRAIN->OUT edge from next-state values so r_0 is included
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                 zero_q <= 1'b0;
    else if (clr)                zero_q <= 1'b0;
    else if (state == ST_DRAIN)  zero_q <= ~|nz;
  end
  assign synd_zero_o = zero_q;
`else
  assign synd_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_hqc_rsdecod_syndrome.sv
// Bench: all three security levels side by side, checked against a direct-sum
// GF(2^8) syndrome model (log/exp tables) on every cycle.
`timescale 1ns/1ps
module tb_hqc_rsdecod_syndrome;

  localparam int NL = 3;
  localparam int SEC [NL] = '{128, 192, 256};
  localparam int N1T [NL] = '{46, 56, 90};
  localparam int DT  [NL] = '{15, 16, 29};
`ifdef HQC_RS_SYND_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic bp_en = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  int run_id = 0, run_kind = 0, t_start = 0;

  function automatic void chk(input string nm, input int l, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s sec=%0d cycle=%0d: got 0x%0h, want 0x%0h", nm, SEC[l], cyc, act, exp);
  endfunction

  // ---------------- model ----------------
  logic [7:0] gexp [255];
  int         glog [256];
  logic [7:0] mem   [NL][128];
  logic [7:0] exp_s [NL][58];
  logic       exp_zero [NL];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  task automatic build_tables();
    int v;
    v = 1;
    for (int e = 0; e < 255; e++) begin
      gexp[e] = 8'(v);
      glog[v] = e;
      v = v * 2;
      if (v >= 256) v = v ^ 'h11D;
    end
  endtask

  // kind: 0 all-zero, 1 r_0=1, 2 r_1=1, 3 random
  task automatic load(input int kind);
    for (int l = 0; l < NL; l++) begin
      for (int j = 0; j < 128; j++)
        mem[l][j] = (kind == 3 && j < N1T[l]) ? 8'($urandom) : 8'h00;
      if (kind == 1) mem[l][0] = 8'h01;
      if (kind == 2) mem[l][1] = 8'h01;
      exp_zero[l] = 1'b1;
      for (int i = 1; i <= 2 * DT[l]; i++) begin
        logic [7:0] s;
        s = 8'h00;
        for (int j = 0; j < N1T[l]; j++) s ^= gmul(mem[l][j], gexp[(i * j) % 255]);
        exp_s[l][i-1] = s;
        if (s != 0) exp_zero[l] = 1'b0;
      end
    end
  endtask

  // ---------------- DUTs ----------------
  logic [NL-1:0] busy_a, done_a, rd_a, valid_a, zero_a, rdy_a;
  logic [6:0]    addr_a [NL];
  logic [7:0]    synd_a [NL];
  logic [5:0]    idx_a  [NL];

  for (genvar g = 0; g < NL; g++) begin : lv
    localparam int AW = (g == 2) ? 7 : 6;
    logic          busy, done, rd, valid, zero, rdy;
    logic [AW-1:0] addr;
    logic [7:0]    din, synd;
    logic [5:0]    idx;
    int            stall_n;

    hqc_rsdecod_syndrome #(.PARAM_SECURITY(SEC[g])) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
      .ram_din_i(din), .ram_din_rd_o(rd), .ram_din_addr_o(addr),
      .synd_o(synd), .synd_idx_o(idx), .synd_valid_o(valid),
      .synd_ready_i(rdy), .synd_zero_o(zero)
    );

    always @(posedge clk) if (rd) din <= mem[g][addr];

    // ready low for 3 cycles once index 5 is presented
    initial begin
      rdy = 1'b1;
      stall_n = 0;
      forever begin
        @(posedge clk); #1;
        if (!busy) stall_n = 0;
        if (bp_en && valid && idx == 6'd5 && stall_n < 3) begin
          rdy = 1'b0;
          stall_n++;
        end else rdy = 1'b1;
      end
    end

    assign busy_a[g] = busy;  assign done_a[g] = done;   assign rd_a[g] = rd;
    assign valid_a[g] = valid; assign zero_a[g] = zero;  assign rdy_a[g] = rdy;
    assign addr_a[g] = 7'(addr); assign synd_a[g] = synd; assign idx_a[g] = idx;
  end

  // ---------------- compare ----------------
  logic [NL-1:0] running = '0;
  int exp_idx [NL] = '{0, 0, 0};
  int my_run  [NL] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int l = 0; l < NL; l++) begin
      int dt, ns;
      logic ev;
      ns = 2 * DT[l];
      dt = cyc - t_start;
      if (!rst_n) begin
        running[l] = 1'b0;
        my_run[l]  = run_id;
        chk("rst_ctrl", l, {busy_a[l], done_a[l], rd_a[l], valid_a[l], zero_a[l]}, 0);
        chk("rst_data", l, {addr_a[l], synd_a[l], idx_a[l]}, 0);
      end else begin
        if (my_run[l] != run_id) begin
          my_run[l]  = run_id;
          running[l] = 1'b1;
          exp_idx[l] = 0;
          case (run_kind)
            0: chk("model_zero", l, exp_zero[l], 1);
            1: chk("model_r0", l, exp_s[l][ns-1], 'h01);
            2: begin
              chk("model_a1", l, exp_s[l][0], 'h02);
              chk("model_a2", l, exp_s[l][1], 'h04);
              chk("model_a8", l, exp_s[l][7], 'h1D);
            end
            default: ;
          endcase
        end
        chk("busy", l, busy_a[l], running[l]);
        chk("rd", l, rd_a[l], running[l] && dt < N1T[l]);
        if (rd_a[l]) chk("addr", l, addr_a[l], N1T[l] - 1 - dt);
        ev = running[l] && dt >= N1T[l] + 1 && exp_idx[l] < ns;
        chk("valid", l, valid_a[l], ev);
        if (valid_a[l] && exp_idx[l] < ns) begin
          chk("synd_idx", l, idx_a[l], exp_idx[l]);
          chk("synd", l, synd_a[l], exp_s[l][exp_idx[l]]);
        end
        chk("done", l, done_a[l], running[l] && exp_idx[l] == ns);
        if (valid_a[l] || done_a[l]) chk("zero", l, zero_a[l], ZD && exp_zero[l]);
        if (done_a[l]) chk("done_cycle", l, dt, N1T[l] + 1 + ns + (bp_en ? 3 : 0));
        if (running[l] && exp_idx[l] == ns) running[l] = 1'b0;
        if (valid_a[l] && rdy_a[l]) exp_idx[l]++;
        if (running[l] && dt > 300) begin
          chk("timeout", l, 1, 0);
          running[l] = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic kick(input int kind);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t_start  = cyc;
    run_kind = kind;
    run_id++;
  endtask

  task automatic poke_after(input int n);
    repeat (n) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (running != '0 && n < 400);
    @(posedge clk);
  endtask

  initial begin
    build_tables();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    load(0); kick(0); wait_idle();
    load(1); kick(1); wait_idle();
    load(2); kick(2); wait_idle();
    load(3); bp_en = 1'b1; kick(3); wait_idle(); bp_en = 1'b0;
    load(3); kick(3); poke_after(20); poke_after(40); wait_idle();
    load(3); kick(3);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    load(3); kick(3); wait_idle();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
